// File: rtl/diff_square_pkg.sv
// rtl/diff_square_pkg.sv - shared types and constants for the diff-square sequencer
package diff_square_pkg;

    localparam int DS_DATA_W    = 16;
    localparam int DS_ADDR_W    = 3;
    localparam int DS_SUM_ADDR  = 0;
    localparam int DS_DIFF_ADDR = 1;
    localparam int DS_PROD_ADDR = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR_SUM  = 3'd1,
        ST_WR_DIFF = 3'd2,
        ST_RD_A    = 3'd3,
        ST_RD_B    = 3'd4,
        ST_WR_PROD = 3'd5,
        ST_RD_PROD = 3'd6,
        ST_DONE    = 3'd7
    } ds_state_e;

endpackage

// File: rtl/diff_square_seq.sv
// rtl/diff_square_seq.sv - start/done sequencer computing (x+y)*(y-x) through external RAM and multiplier
module diff_square_seq
    import diff_square_pkg::*;
#(
    parameter int DATA_W    = DS_DATA_W,
    parameter int ADDR_W    = DS_ADDR_W,
    parameter int SUM_ADDR  = DS_SUM_ADDR,
    parameter int DIFF_ADDR = DS_DIFF_ADDR,
    parameter int PROD_ADDR = DS_PROD_ADDR
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [DATA_W-1:0]   i_x,
    input  logic [DATA_W-1:0]   i_y,
    output logic                o_busy,
    output logic                o_done,
    output logic [DATA_W-1:0]   o_product,
    output logic                o_ovf,
    output logic [ADDR_W-1:0]   o_ram_addr,
    output logic                o_ram_load,
    output logic [DATA_W-1:0]   o_ram_din,
    input  logic [DATA_W-1:0]   i_ram_dout,
    output logic [DATA_W-1:0]   o_mul_a,
    output logic [DATA_W-1:0]   o_mul_b,
    input  logic [2*DATA_W-1:0] i_mul_p
);

    localparam logic [ADDR_W-1:0] A_SUM  = ADDR_W'(SUM_ADDR);
    localparam logic [ADDR_W-1:0] A_DIFF = ADDR_W'(DIFF_ADDR);
    localparam logic [ADDR_W-1:0] A_PROD = ADDR_W'(PROD_ADDR);

    ds_state_e         r_state;
    logic [DATA_W-1:0] r_x;
    logic [DATA_W-1:0] r_y;
    logic [DATA_W-1:0] r_mul_a;
    logic [DATA_W-1:0] r_mul_b;
    logic [DATA_W-1:0] r_product;
    logic              r_ovf;
    logic              r_ovf_next;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W-1:0] r_ram_addr;
    logic              r_ram_load;
    logic [DATA_W-1:0] r_ram_din;

    // Sequencer: each state's RAM controls are registered on the edge that enters it
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_mul_a    <= '0;
            r_mul_b    <= '0;
            r_product  <= '0;
            r_ovf      <= 1'b0;
            r_ovf_next <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ram_addr <= '0;
            r_ram_load <= 1'b0;
            r_ram_din  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_x        <= i_x;
                        r_y        <= i_y;
                        r_ram_addr <= A_SUM;
                        r_ram_load <= 1'b1;
                        r_ram_din  <= i_x + i_y;
                        r_busy     <= 1'b1;
                        r_state    <= ST_WR_SUM;
                    end
                end
                ST_WR_SUM: begin
                    r_ram_addr <= A_DIFF;
                    r_ram_load <= 1'b1;
                    r_ram_din  <= r_y - r_x;
                    r_state    <= ST_WR_DIFF;
                end
                ST_WR_DIFF: begin
                    r_ram_addr <= A_SUM;
                    r_ram_load <= 1'b0;
                    r_ram_din  <= '0;
                    r_state    <= ST_RD_A;
                end
                ST_RD_A: begin
                    r_mul_a    <= i_ram_dout;
                    r_ram_addr <= A_DIFF;
                    r_state    <= ST_RD_B;
                end
                ST_RD_B: begin
                    r_mul_b    <= i_ram_dout;
                    r_ram_addr <= A_PROD;
                    r_ram_load <= 1'b1;
                    r_state    <= ST_WR_PROD;
                end
                ST_WR_PROD: begin
                    r_ovf_next <= |i_mul_p[2*DATA_W-1:DATA_W];
                    r_ram_load <= 1'b0;
                    r_state    <= ST_RD_PROD;
                end
                ST_RD_PROD: begin
                    r_product  <= i_ram_dout;
                    r_ovf      <= r_ovf_next;
                    r_done     <= 1'b1;
                    r_state    <= ST_DONE;
                end
                ST_DONE: begin
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    // The product only exists after rX/rY settle, so its write data comes straight from the multiplier;
    // the write enable is masked by reset so an aborting edge never writes the RAM
    always_comb begin
        o_ram_din  = (r_state == ST_WR_PROD) ? i_mul_p[DATA_W-1:0] : r_ram_din;
        o_ram_load = r_ram_load & ~i_reset;
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_product  = r_product;
    assign o_ovf      = r_ovf;
    assign o_ram_addr = r_ram_addr;
    assign o_mul_a    = r_mul_a;
    assign o_mul_b    = r_mul_b;

endmodule

// File: tb/tb_diff_square_seq.sv
// tb/tb_diff_square_seq.sv - self-checking bench for diff_square_seq with RAM and multiplier models
module tb_diff_square_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] x;
    logic [15:0] y;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        ovf;
    logic [2:0]  ram_addr;
    logic        ram_load;
    logic [15:0] ram_din;
    logic [15:0] ram_dout;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic [31:0] mul_p;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    diff_square_seq dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_start    (start),
        .i_x        (x),
        .i_y        (y),
        .o_busy     (busy),
        .o_done     (done),
        .o_product  (product),
        .o_ovf      (ovf),
        .o_ram_addr (ram_addr),
        .o_ram_load (ram_load),
        .o_ram_din  (ram_din),
        .i_ram_dout (ram_dout),
        .o_mul_a    (mul_a),
        .o_mul_b    (mul_b),
        .i_mul_p    (mul_p)
    );

    // Environment: shared 8x16 RAM and combinational multiplier
    logic [15:0] mem [8];
    assign ram_dout = mem[ram_addr];
    assign mul_p    = {16'd0, mul_a} * {16'd0, mul_b};
    always @(posedge clk) if (ram_load) mem[ram_addr] <= ram_din;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycles elapsed since the accepting edge (0 = idle) plus the expected results
    int          m_cnt = 0;
    logic [15:0] m_sum, m_diff, m_plo, m_product;
    logic        m_povf, m_ovf;
    logic        chk_en = 1'b0;

    always @(posedge clk) begin
        logic [31:0] full;
        if (reset) begin
            m_cnt     = 0;
            m_product = 16'd0;
            m_ovf     = 1'b0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_sum  = x + y;
                m_diff = y - x;
                full   = {16'd0, m_sum} * {16'd0, m_diff};
                m_plo  = full[15:0];
                m_povf = (full[31:16] != 16'd0);
                m_cnt  = 1;
            end
        end else begin
            m_cnt = (m_cnt == 7) ? 0 : m_cnt + 1;
            if (m_cnt == 7) begin
                m_product = m_plo;
                m_ovf     = m_povf;
            end
        end
        chk_en <= 1'b1;
    end

    // Compare every cycle away from the active edge
    int done_seen = 0;
    always @(negedge clk) begin
        logic exp_load;
        if (chk_en) begin
            exp_load = (m_cnt == 1 || m_cnt == 2 || m_cnt == 5) && !reset;
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("done", 32'(done), 32'(m_cnt == 7));
            chk("product", 32'(product), 32'(m_product));
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("ram_load", 32'(ram_load), 32'(exp_load));
            if (exp_load) begin
                case (m_cnt)
                    1: begin chk("addr_sum", 32'(ram_addr), 32'd0); chk("din_sum", 32'(ram_din), 32'(m_sum)); end
                    2: begin chk("addr_diff", 32'(ram_addr), 32'd1); chk("din_diff", 32'(ram_din), 32'(m_diff)); end
                    default: begin chk("addr_prod", 32'(ram_addr), 32'd2); chk("din_prod", 32'(ram_din), 32'(m_plo)); end
                endcase
            end else begin
                chk("din_idle", 32'(ram_din), 32'd0);
            end
            if (done) done_seen++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a start and wait for done; checks the 7-cycle latency
    task automatic run_op(input logic [15:0] xv, input logic [15:0] yv, input string name);
        int n;
        start = 1'b1; x = xv; y = yv;
        tick();
        start = 1'b0;
        n = 1;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, 32'(n), 32'd7);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; x = '0; y = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        tick();
        tick();

        run_op(16'd10, 16'd20, "op1");
        chk("op1_ram0", 32'(mem[0]), 32'd30);
        chk("op1_ram1", 32'(mem[1]), 32'd10);
        chk("op1_ram2", 32'(mem[2]), 32'd300);
        chk("op1_product", 32'(product), 32'd300);
        chk("op1_ovf", 32'(ovf), 32'd0);

        run_op(16'd20, 16'd10, "op2");
        chk("op2_ram1", 32'(mem[1]), 32'd65526);
        chk("op2_product", 32'(product), 32'h0000_FED4);
        chk("op2_ovf", 32'(ovf), 32'd1);
        chk("op2_ram2", 32'(mem[2]), 32'h0000_FED4);

        run_op(16'd300, 16'd700, "op3");
        chk("op3_ram0", 32'(mem[0]), 32'd1000);
        chk("op3_ram1", 32'(mem[1]), 32'd400);
        chk("op3_product", 32'(product), 32'h0000_1A80);
        chk("op3_ovf", 32'(ovf), 32'd1);

        // Start re-pulsed in WR_DIFF and in DONE must be ignored
        done_seen = 0;
        start = 1'b1; x = 16'd7; y = 16'd9;
        tick();
        start = 1'b0;
        tick();
        start = 1'b1; x = 16'd1; y = 16'd2;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("ign_in_done", 32'(done), 32'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_idle", 32'(busy), 32'd0);
        repeat (3) tick();
        chk("ign_product", 32'(product), 32'd32);
        chk("ign_done_count", 32'(done_seen), 32'd1);

        // Reset during RD_B aborts
        start = 1'b1; x = 16'd3; y = 16'd9;
        tick();
        start = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        tick();
        run_op(16'd5, 16'd5, "op5");
        chk("op5_product", 32'(product), 32'd0);
        chk("op5_ovf", 32'(ovf), 32'd0);
        chk("op5_ram1", 32'(mem[1]), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/diff_square_seq.md
Name: diff_square_seq

Overview:
- Synchronous sequencer that computes product = (x+y)*(y-x).
- Drives the shared 8x16 RAM (async read, write on clk rising edge when load=1) and the combinational 16x16->32 multiplier.
- Replaces the free-running initial-block test sequence with a start/done handshake.
- Sits between the system top and the ram/multiplication instances; owns their control, address and data inputs.

Parameters:
- DATA_W, 16, operand/RAM word width.
- ADDR_W, 3, RAM address width.
- SUM_ADDR, 0, RAM slot for x+y.
- DIFF_ADDR, 1, RAM slot for y-x.
- PROD_ADDR, 2, RAM slot for the product.

Ports:
- clk  in  1  system clock, all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- x  in  DATA_W  operand x, captured with start.
- y  in  DATA_W  operand y, captured with start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse; product/ovf valid.
- product  out  DATA_W  low DATA_W bits of result; held until next accepted start.
- ovf  out  1  upper DATA_W product bits nonzero; held with product.
- ram_addr  out  ADDR_W  RAM address.
- ram_load  out  1  RAM write enable.
- ram_din  out  DATA_W  RAM write data.
- ram_dout  in  DATA_W  RAM read data, combinational from ram_addr.
- mul_a  out  DATA_W  multiplier operand A, register rX.
- mul_b  out  DATA_W  multiplier operand B, register rY.
- mul_p  in  2*DATA_W  multiplier result, combinational.

Behaviour:
- Reset, synchronous and active-high: state=IDLE; busy=0, done=0, product=0, ovf=0, ram_load=0, ram_addr=0, ram_din=0, rX=rY=0; latched x/y cleared.
- Reset mid-operation aborts the sequence. No RAM write occurs on the reset edge; the RAM contents themselves are not cleared.
- Arithmetic: sum = x+y mod 2^DATA_W; diff = y-x mod 2^DATA_W (unsigned wrap); full product = mul_p, unsigned; product = mul_p[DATA_W-1:0]; ovf = |mul_p[2*DATA_W-1:DATA_W].
- FSM, one cycle per state; k = edge at which start is accepted:
  - IDLE: start=1 -> latch x,y -> WR_SUM. Otherwise stay.
  - WR_SUM: ram_addr=SUM_ADDR, ram_load=1, ram_din=sum; write at edge k+1 -> WR_DIFF.
  - WR_DIFF: ram_addr=DIFF_ADDR, ram_load=1, ram_din=diff; write at edge k+2 -> RD_A.
  - RD_A: ram_addr=SUM_ADDR, ram_load=0; rX<=ram_dout at edge k+3 -> RD_B.
  - RD_B: ram_addr=DIFF_ADDR; rY<=ram_dout at edge k+4 -> WR_PROD.
  - WR_PROD: ram_addr=PROD_ADDR, ram_load=1, ram_din=mul_p[DATA_W-1:0]; ovf_next captured; write at edge k+5 -> RD_PROD.
  - RD_PROD: ram_addr=PROD_ADDR, ram_load=0; product<=ram_dout, ovf<=ovf_next at edge k+6 -> DONE.
  - DONE: done=1 for exactly this cycle -> IDLE at edge k+7.
- Latency: done is high in the 7th cycle after the start-accept edge. Earliest next accept is edge k+8.
- start while busy (including DONE) is ignored, not queued. x/y changes after acceptance have no effect.
- ram_load is high only in WR_SUM, WR_DIFF and WR_PROD. In all other states ram_addr holds its last value and ram_din=0.
- product/ovf change only at the RD_PROD edge. x=y gives diff=0, product=0, ovf=0.

Decomposition:
- Shared package diff_square_pkg: state enum (IDLE, WR_SUM, WR_DIFF, RD_A, RD_B, WR_PROD, RD_PROD, DONE; 3-bit encoding); default DATA_W/ADDR_W and slot-address constants.
- Single module, no sub-module; ram and multiplication are instantiated by the parent, not inside this block.

Test Plan:
- Reset held 2 cycles, then released -> all outputs 0, busy=0, no ram_load pulse.
- x=10, y=20, start 1 cycle -> RAM[0]=30, RAM[1]=10, RAM[2]=300; done 7 cycles after accept; product=300, ovf=0.
- x=20, y=10 -> diff=65526; product=65236 (0xFED4), ovf=1, RAM[2]=0xFED4.
- x=300, y=700 -> sum=1000, diff=400, full=400000; product=6784 (0x1A80), ovf=1.
- start re-pulsed in WR_DIFF and in DONE with x=1, y=2 -> ignored; first result unchanged; exactly one done pulse.
- reset asserted in RD_B -> next cycle state IDLE, busy=0, product=0; fresh start with x=5, y=5 -> product=0, ovf=0.
